// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control bundle (stall/if_ready/flush/branch in; pc/ce/misalign/redirect_pending out); master = pc_gen side
interface pc_gen_if #(parameter int ADDR_W = 32);
  logic              stall;
  logic              if_ready;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              misalign;
  logic              redirect_pending;
  modport master (
    input  stall, if_ready, flush, flush_pc, branch_valid, branch_target,
    output pc, ce, misalign, redirect_pending
  );
  modport slave (
    output stall, if_ready, flush, flush_pc, branch_valid, branch_target,
    input  pc, ce, misalign, redirect_pending
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with flush/branch redirect and stalled-branch buffer; ports clk, rst (async high), f (pc_gen_if.master)
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(32'hBFC0_0000),
  parameter int                INC        = 4,
  parameter int                ALIGN_BITS = 2
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.master f
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n, pend_q, pend_n;
  logic              ce_q, rp_q, rp_n, adv;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= BOOT;
      pc_q   <= RESET_VEC;
      ce_q   <= 1'b0;
      rp_q   <= 1'b0;
      pend_q <= '0;
    end else begin
      state  <= state_n;
      pc_q   <= pc_n;
      ce_q   <= 1'b1;
      rp_q   <= rp_n;
      pend_q <= pend_n;
    end
  always_comb begin
    adv     = state == RUN && ce_q && f.if_ready && !f.stall;
    state_n = RUN;
    pc_n    = pc_q;
    pend_n  = pend_q;
    rp_n    = rp_q;
    if (state == BOOT)
      pc_n = f.flush ? f.flush_pc : pc_q;
    else if (f.flush) begin
      pc_n = f.flush_pc;
      rp_n = 1'b0;
    end else if (f.branch_valid && adv) begin
      pc_n = f.branch_target;
      rp_n = 1'b0;
    end else if (f.branch_valid) begin
      pend_n = f.branch_target;
      rp_n   = 1'b1;
    end else if (rp_q && adv) begin
      pc_n = pend_q;
      rp_n = 1'b0;
    end else if (adv)
      pc_n = pc_q + ADDR_W'(INC);
  end
  assign f.pc               = pc_q;
  assign f.ce               = ce_q;
  assign f.redirect_pending = rp_q;
  if (ALIGN_BITS == 0) begin : g_no_align
    assign f.misalign = 1'b0;
  end else begin : g_align
    assign f.misalign = ce_q && |pc_q[ALIGN_BITS-1:0];
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plus random stimulus against a behavioural pc model
module tb_pc_gen;
  localparam logic [31:0] RV = 32'hBFC0_0000;
  logic clk = 1'b0, rst;
  int checks = 0, errors = 0;
  logic        m_run, m_rp;
  logic [31:0] m_pc, m_pend;
  pc_gen_if #(32) bus ();
  pc_gen dut (.clk(clk), .rst(rst), .f(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_model();
    chk("pc", bus.pc, m_pc);
    chk("ce", 32'(bus.ce), 32'(m_run));
    chk("pending", 32'(bus.redirect_pending), 32'(m_rp));
    chk("misalign", 32'(bus.misalign), 32'(m_run && m_pc[1:0] != 2'b00));
  endtask
  task automatic model_reset();
    m_run = 1'b0; m_rp = 1'b0; m_pc = RV; m_pend = '0;
  endtask
  task automatic step();
    logic adv;
    adv = m_run && bus.if_ready && !bus.stall;
    if (!m_run) begin
      if (bus.flush) m_pc = bus.flush_pc;
      m_run = 1'b1;
    end else if (bus.flush) begin
      m_pc = bus.flush_pc; m_rp = 1'b0;
    end else if (bus.branch_valid && adv) begin
      m_pc = bus.branch_target; m_rp = 1'b0;
    end else if (bus.branch_valid) begin
      m_pend = bus.branch_target; m_rp = 1'b1;
    end else if (m_rp && adv) begin
      m_pc = m_pend; m_rp = 1'b0;
    end else if (adv)
      m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
    chk_model();
  endtask
  task automatic set(input logic st, input logic rdy, input logic fl, input logic [31:0] fp,
                     input logic bv, input logic [31:0] bt);
    bus.stall = st; bus.if_ready = rdy; bus.flush = fl; bus.flush_pc = fp;
    bus.branch_valid = bv; bus.branch_target = bt;
  endtask
  initial begin
    rst = 1'b1;
    set(0, 1, 0, '0, 0, '0);
    model_reset();
    #12;
    chk("rst_pc", bus.pc, RV);
    chk("rst_ce", 32'(bus.ce), 32'd0);
    rst = 1'b0;
    step();
    chk("boot_pc", bus.pc, 32'hBFC0_0000);
    chk("boot_ce", 32'(bus.ce), 32'd1);
    step();
    chk("seq1", bus.pc, 32'hBFC0_0004);
    step();
    chk("seq2", bus.pc, 32'hBFC0_0008);
    step(); step();
    chk("at10", bus.pc, 32'hBFC0_0010);
    set(1, 1, 0, '0, 0, '0);
    repeat (3) step();
    chk("stall_hold", bus.pc, 32'hBFC0_0010);
    set(0, 1, 0, '0, 0, '0);
    step();
    chk("stall_rel", bus.pc, 32'hBFC0_0014);
    set(0, 0, 0, '0, 0, '0);
    repeat (2) step();
    chk("rdy_hold", bus.pc, 32'hBFC0_0014);
    set(0, 1, 0, '0, 0, '0);
    step();
    chk("rdy_rel", bus.pc, 32'hBFC0_0018);
    step(); step();
    set(0, 1, 0, '0, 1, 32'h8000_1000);
    step();
    chk("br_adv", bus.pc, 32'h8000_1000);
    chk("br_adv_pend", 32'(bus.redirect_pending), 32'd0);
    set(1, 1, 0, '0, 1, 32'h8000_2000);
    step();
    chk("br_stall_pend", 32'(bus.redirect_pending), 32'd1);
    chk("br_stall_hold", bus.pc, 32'h8000_1000);
    set(1, 1, 0, '0, 0, '0);
    step();
    set(0, 1, 0, '0, 0, '0);
    step();
    chk("br_pend_apply", bus.pc, 32'h8000_2000);
    chk("br_pend_clr", 32'(bus.redirect_pending), 32'd0);
    set(1, 1, 1, 32'hBFC0_0380, 1, 32'h8000_3000);
    step();
    chk("flush_pri", bus.pc, 32'hBFC0_0380);
    chk("flush_pri_pend", 32'(bus.redirect_pending), 32'd0);
    set(1, 1, 0, '0, 1, 32'h8000_4000);
    step();
    set(1, 1, 1, 32'hBFC0_0400, 0, '0);
    step();
    chk("flush_clr_pend", 32'(bus.redirect_pending), 32'd0);
    set(0, 1, 1, 32'hFFFF_FFFC, 0, '0);
    step();
    set(0, 1, 0, '0, 0, '0);
    step();
    chk("wrap", bus.pc, 32'h0000_0000);
    set(0, 1, 0, '0, 1, 32'h8000_0002);
    step();
    chk("misalign", 32'(bus.misalign), 32'd1);
    set(1, 1, 0, '0, 1, 32'h8000_5000);
    step();
    chk("pre_rst_pend", 32'(bus.redirect_pending), 32'd1);
    set(1, 1, 0, '0, 0, '0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_pc", bus.pc, 32'hBFC0_0000);
    chk("arst_ce", 32'(bus.ce), 32'd0);
    chk("arst_pend", 32'(bus.redirect_pending), 32'd0);
    #2 rst = 1'b0;
    set(0, 1, 1, 32'h0000_1000, 0, '0);
    step();
    chk("boot_flush", bus.pc, 32'h0000_1000);
    for (int i = 0; i < 400; i++) begin
      set($urandom_range(3) == 0, $urandom_range(3) != 0, $urandom_range(19) == 0,
          {$urandom} & 32'hFFFF_FFFC, $urandom_range(5) == 0,
          $urandom_range(15) == 0 ? $urandom : ({$urandom} & 32'hFFFF_FFFC));
      if ($urandom_range(99) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1 chk_model();
        #2 rst = 1'b0;
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
